spi_target_core: RTL



---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 29 ++
 rtl/spi_target_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target core.
// Contents: FSM state type, default idle byte and synchronizer depth, SPI mode constants.
package spi_pkg;

    // Frame state: StIdle while cs_n is high, StActive while the target is selected.
    typedef enum logic {
        StIdle,
        StActive
    } spi_state_e;

    localparam logic [7:0]  IdleByteDefault   = 8'hFF;
    localparam int unsigned SyncStagesDefault = 2;

    // Only mode 0, MSB first, is supported.
    localparam logic SpiCpol     = 1'b0;
    localparam logic SpiCpha     = 1'b0;
    localparam logic SpiMsbFirst = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous single-bit input.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; every flop resets to RESET_VAL
//   d_i    asynchronous input
//   q_o    input synchronized to clk, STAGES cycles of latency
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target_core.sv
// SPI target (mode 0, MSB first) running entirely in the clk domain.
// sclk, cs_n and mosi are oversampled through synchronizers; clk must be at least 4x sclk.
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   sclk_i, cs_n_i     SPI clock and active-low select from the master (asynchronous)
//   mosi_i             master-to-target data
//   miso_o, miso_oe_o  target-to-master data and its output enable (high while selected)
//   rx_data_o          last complete received byte
//   rx_valid_o         one-cycle pulse, rx_data_o updated
//   rx_first_o         with rx_valid_o: first byte since cs_n fell
//   tx_data_i          byte to transmit next
//   tx_valid_i         tx_data_i offered; accepted when tx_ready_o is also high
//   tx_ready_o         one-byte transmit buffer is empty
//   tx_underrun_o      one-cycle pulse, IDLE_BYTE loaded because the buffer was empty
//   frame_abort_o      one-cycle pulse, cs_n rose with a partial byte in flight
module spi_target_core
    import spi_pkg::*;
#(
    parameter logic [7:0]  IDLE_BYTE   = IdleByteDefault,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_first_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_underrun_o,
    output logic       frame_abort_o
);

    logic sclk_s, cs_n_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sclk_i),
        .q_o   (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cs_n_i),
        .q_o   (cs_n_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (mosi_i),
        .q_o   (mosi_s)
    );

    spi_state_e state_q, state_d;
    logic       sclk_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       reload_q, reload_d;     // byte finished, reload shifter on the next sclk fall
    logic       first_q, first_d;       // no byte completed yet in this frame
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       ready_en_q;             // holds tx_ready_o low until the cycle after reset
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       underrun_q, underrun_d;
    logic       abort_q, abort_d;

    logic sclk_rise, sclk_fall, tx_accept, load;

    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_s & sclk_prev_q;
    assign tx_ready_o = ready_en_q & ~buf_full_q;
    assign tx_accept  = tx_valid_i & tx_ready_o;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        reload_d   = reload_q;
        first_d    = first_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        underrun_d = 1'b0;
        abort_d    = 1'b0;
        load       = 1'b0;

        if (tx_accept) begin
            buf_d      = tx_data_i;
            buf_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!cs_n_s) begin
                    state_d   = StActive;
                    bit_cnt_d = 3'd0;
                    reload_d  = 1'b0;
                    first_d   = 1'b1;
                    load      = 1'b1;
                end
            end
            StActive: begin
                if (cs_n_s) begin
                    state_d   = StIdle;
                    abort_d   = (bit_cnt_q != 3'd0);
                    bit_cnt_d = 3'd0;
                    reload_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        reload_d   = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
        endcase

        // The buffer cannot be accepted while full, so a load never races an accept.
        if (load) begin
            if (buf_full_q) begin
                tx_shift_d = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shift_d = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= 8'd0;
            reload_q    <= 1'b0;
            first_q     <= 1'b0;
            buf_q       <= 8'd0;
            buf_full_q  <= 1'b0;
            ready_en_q  <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_s;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            reload_q    <= reload_d;
            first_q     <= first_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            ready_en_q  <= 1'b1;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign miso_oe_o     = (state_q == StActive);
    assign miso_o        = (state_q == StActive) & tx_shift_q[7];
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_first_o    = rx_first_q;
    assign tx_underrun_o = underrun_q;
    assign frame_abort_o = abort_q;

endmodule
